// File: rtl/regfile_wb_arbiter_if.sv
// Write-back arbiter bus: ALU (A) and multi-cycle (B) write-back requests,
// decode-stage issue/source fields, register-file write port and scoreboard outputs.
interface regfile_wb_arbiter_if;
    logic        a_valid;
    logic [4:0]  a_rd;
    logic [31:0] a_data;
    logic        a_ready;

    logic        b_valid;
    logic [4:0]  b_rd;
    logic [31:0] b_data;
    logic        b_ready;

    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic [4:0]  rs;
    logic [4:0]  rt;

    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        hazard;
    logic [31:0] busy;

    modport master (
        output a_valid, a_rd, a_data, b_valid, b_rd, b_data,
               issue_valid, issue_rd, rs, rt,
        input  a_ready, b_ready, wb_we, wb_rd, wb_data, hazard, busy
    );

    modport slave (
        input  a_valid, a_rd, a_data, b_valid, b_rd, b_data,
               issue_valid, issue_rd, rs, rt,
        output a_ready, b_ready, wb_we, wb_rd, wb_data, hazard, busy
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port between the ALU and the multi-cycle unit,
// with starvation protection for the multi-cycle side and a busy-register scoreboard.
module regfile_wb_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input logic            clock,
    input logic            reset,
    regfile_wb_arbiter_if.slave bus
);

    logic [3:0]  starve_cnt;
    logic        starve_mode;
    logic        a_acc;
    logic        b_acc;
    logic [31:0] busy;
    logic [31:0] busy_next;

    always_comb begin
        starve_mode = (starve_cnt == 4'(STARVE_LIMIT));
        bus.a_ready = !starve_mode;
        bus.b_ready = starve_mode || !bus.a_valid;
        a_acc       = bus.a_valid && bus.a_ready;
        b_acc       = bus.b_valid && bus.b_ready;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bus.wb_we   <= 1'b0;
            bus.wb_rd   <= '0;
            bus.wb_data <= '0;
        end else if (a_acc) begin
            bus.wb_we   <= (bus.a_rd != '0);
            bus.wb_rd   <= bus.a_rd;
            bus.wb_data <= bus.a_data;
        end else if (b_acc) begin
            bus.wb_we   <= (bus.b_rd != '0);
            bus.wb_rd   <= bus.b_rd;
            bus.wb_data <= bus.b_data;
        end else begin
            bus.wb_we   <= 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (!bus.b_valid || b_acc) begin
            starve_cnt <= '0;
        end else if (!starve_mode) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end

    // Issue is applied after the clear so a same-register set/clear leaves it busy.
    always_comb begin
        busy_next = busy;
        if (b_acc) begin
            busy_next[bus.b_rd] = 1'b0;
        end
        if (bus.issue_valid) begin
            busy_next[bus.issue_rd] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

    always_comb begin
        bus.busy   = busy;
        bus.hazard = ((bus.rs != '0) && busy[bus.rs]) ||
                     ((bus.rt != '0) && busy[bus.rt]) ||
                     (bus.issue_valid && busy[bus.issue_rd]);
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed vector table, reset/starvation sequences
// and random traffic checked against a behavioural model.
module tb_regfile_wb_arbiter;

    localparam int unsigned LIMIT = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    regfile_wb_arbiter_if bus();

    regfile_wb_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        bit        a_valid;
        bit [4:0]  a_rd;
        bit [31:0] a_data;
        bit        b_valid;
        bit [4:0]  b_rd;
        bit [31:0] b_data;
        bit        issue_valid;
        bit [4:0]  issue_rd;
        bit [4:0]  rs;
        bit [4:0]  rt;
    } in_t;

    typedef struct {
        in_t       in;
        bit        e_a_ready;
        bit        e_b_ready;
        bit        e_hazard;
        bit        e_we;
        bit [4:0]  e_rd;
        bit [31:0] e_data;
        bit [31:0] e_busy;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: which registers await a multi-cycle result, how long B has waited,
    // and what the write port should present.
    bit [31:0]   m_busy;
    int unsigned m_wait;
    bit          m_we;
    bit [4:0]    m_rd;
    bit [31:0]   m_data;

    logic pre_a_ready, pre_b_ready, pre_hazard;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic in_t idle();
        in_t v;
        v = '{default: '0};
        return v;
    endfunction

    task automatic drive(input in_t v);
        bus.a_valid     = v.a_valid;
        bus.a_rd        = v.a_rd;
        bus.a_data      = v.a_data;
        bus.b_valid     = v.b_valid;
        bus.b_rd        = v.b_rd;
        bus.b_data      = v.b_data;
        bus.issue_valid = v.issue_valid;
        bus.issue_rd    = v.issue_rd;
        bus.rs          = v.rs;
        bus.rt          = v.rt;
    endtask

    task automatic model_reset();
        m_busy = '0;
        m_wait = 0;
        m_we   = 0;
        m_rd   = '0;
        m_data = '0;
    endtask

    function automatic bit m_starving();
        return m_wait >= LIMIT;
    endfunction

    function automatic bit m_hazard(input in_t v);
        return (v.rs != 0 && m_busy[v.rs]) || (v.rt != 0 && m_busy[v.rt]) ||
               (v.issue_valid && m_busy[v.issue_rd]);
    endfunction

    task automatic model_edge(input in_t v);
        bit a_win, b_win;
        a_win = v.a_valid && !m_starving();
        b_win = v.b_valid && !a_win && (m_starving() || !v.a_valid);
        if (a_win) begin
            m_we = (v.a_rd != 0); m_rd = v.a_rd; m_data = v.a_data;
        end else if (b_win) begin
            m_we = (v.b_rd != 0); m_rd = v.b_rd; m_data = v.b_data;
        end else begin
            m_we = 0;
        end
        if (!v.b_valid || b_win) m_wait = 0;
        else if (m_wait < LIMIT) m_wait = m_wait + 1;
        if (b_win) m_busy[v.b_rd] = 0;
        if (v.issue_valid && v.issue_rd != 0) m_busy[v.issue_rd] = 1;
    endtask

    task automatic tick(input in_t v);
        @(posedge clock);
        model_edge(v);
        #1;
    endtask

    // Entered one time unit after a rising edge; leaves at the same phase of the next cycle.
    task automatic cycle(input in_t v);
        drive(v);
        #3;
        pre_a_ready = bus.a_ready;
        pre_b_ready = bus.b_ready;
        pre_hazard  = bus.hazard;
        check("a_ready", pre_a_ready, 32'(!m_starving()));
        check("b_ready", pre_b_ready, 32'(m_starving() || !v.a_valid));
        check("hazard",  pre_hazard,  32'(m_hazard(v)));
        tick(v);
        check("wb_we",   bus.wb_we,   32'(m_we));
        check("wb_rd",   bus.wb_rd,   32'(m_rd));
        check("wb_data", bus.wb_data, m_data);
        check("busy",    bus.busy,    m_busy);
    endtask

    vec_t vecs[11];

    initial begin
        in_t v;

        vecs[0]  = '{in: '{1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0},
                     e_a_ready: 1, e_b_ready: 0, e_hazard: 0, e_we: 1, e_rd: 5, e_data: 32'hDEADBEEF, e_busy: 0};
        vecs[1]  = '{in: '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0},
                     e_a_ready: 1, e_b_ready: 1, e_hazard: 0, e_we: 0, e_rd: 5, e_data: 32'hDEADBEEF, e_busy: 0};
        vecs[2]  = '{in: '{0, 0, 0, 0, 0, 0, 1, 9, 0, 0},
                     e_a_ready: 1, e_b_ready: 1, e_hazard: 0, e_we: 0, e_rd: 5, e_data: 32'hDEADBEEF, e_busy: 32'h200};
        vecs[3]  = '{in: '{0, 0, 0, 0, 0, 0, 0, 0, 9, 0},
                     e_a_ready: 1, e_b_ready: 1, e_hazard: 1, e_we: 0, e_rd: 5, e_data: 32'hDEADBEEF, e_busy: 32'h200};
        vecs[4]  = '{in: '{0, 0, 0, 1, 9, 32'hCAFE0009, 0, 0, 9, 0},
                     e_a_ready: 1, e_b_ready: 1, e_hazard: 1, e_we: 1, e_rd: 9, e_data: 32'hCAFE0009, e_busy: 0};
        vecs[5]  = '{in: '{0, 0, 0, 0, 0, 0, 0, 0, 9, 0},
                     e_a_ready: 1, e_b_ready: 1, e_hazard: 0, e_we: 0, e_rd: 9, e_data: 32'hCAFE0009, e_busy: 0};
        vecs[6]  = '{in: '{1, 0, 32'h1234, 0, 0, 0, 1, 0, 0, 0},
                     e_a_ready: 1, e_b_ready: 0, e_hazard: 0, e_we: 0, e_rd: 0, e_data: 32'h1234, e_busy: 0};
        vecs[7]  = '{in: '{0, 0, 0, 0, 0, 0, 1, 3, 0, 0},
                     e_a_ready: 1, e_b_ready: 1, e_hazard: 0, e_we: 0, e_rd: 0, e_data: 32'h1234, e_busy: 32'h8};
        vecs[8]  = '{in: '{0, 0, 0, 1, 3, 32'h33, 1, 3, 0, 0},
                     e_a_ready: 1, e_b_ready: 1, e_hazard: 1, e_we: 1, e_rd: 3, e_data: 32'h33, e_busy: 32'h8};
        vecs[9]  = '{in: '{1, 2, 32'h22, 1, 3, 32'h44, 0, 0, 0, 3},
                     e_a_ready: 1, e_b_ready: 0, e_hazard: 1, e_we: 1, e_rd: 2, e_data: 32'h22, e_busy: 32'h8};
        vecs[10] = '{in: '{0, 0, 0, 1, 3, 32'h44, 0, 0, 0, 0},
                     e_a_ready: 1, e_b_ready: 1, e_hazard: 0, e_we: 1, e_rd: 3, e_data: 32'h44, e_busy: 0};

        // Power-on reset state
        model_reset();
        drive(idle());
        #12;
        check("rst_wb_we",   bus.wb_we,   0);
        check("rst_wb_rd",   bus.wb_rd,   0);
        check("rst_wb_data", bus.wb_data, 0);
        check("rst_busy",    bus.busy,    0);
        check("rst_a_ready", bus.a_ready, 1);
        check("rst_b_ready", bus.b_ready, 1);
        reset = 1'b0;
        tick(idle());

        foreach (vecs[i]) begin
            cycle(vecs[i].in);
            check($sformatf("vec%0d_a_ready", i), pre_a_ready, 32'(vecs[i].e_a_ready));
            check($sformatf("vec%0d_b_ready", i), pre_b_ready, 32'(vecs[i].e_b_ready));
            check($sformatf("vec%0d_hazard", i),  pre_hazard,  32'(vecs[i].e_hazard));
            check($sformatf("vec%0d_wb_we", i),   bus.wb_we,   32'(vecs[i].e_we));
            check($sformatf("vec%0d_wb_rd", i),   bus.wb_rd,   32'(vecs[i].e_rd));
            check($sformatf("vec%0d_wb_data", i), bus.wb_data, vecs[i].e_data);
            check($sformatf("vec%0d_busy", i),    bus.busy,    vecs[i].e_busy);
        end

        // Mid-operation reset with B already waiting: counter and scoreboard must clear
        v = '{1, 5, 32'h1, 1, 7, 32'h77, 1, 8, 0, 0};
        cycle(v);
        cycle(v);
        check("pre_rst_busy",  bus.busy,  32'h100);
        check("pre_rst_wb_we", bus.wb_we, 1);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check("midrst_wb_we",   bus.wb_we,   0);
        check("midrst_wb_rd",   bus.wb_rd,   0);
        check("midrst_wb_data", bus.wb_data, 0);
        check("midrst_busy",    bus.busy,    0);
        check("midrst_a_ready", bus.a_ready, 1);
        check("midrst_b_ready", bus.b_ready, 0);
        reset = 1'b0;
        drive(idle());
        tick(idle());

        // Contention: B waits exactly LIMIT A-accepts, wins once, then A resumes
        for (int i = 0; i < 6; i++) begin
            v = '{1, 5'(10 + i), 32'(i * 32'h111), 1, 7, 32'h77, 0, 0, 0, 0};
            cycle(v);
            check($sformatf("starve%0d_a_ready", i), pre_a_ready, (i == 4) ? 0 : 1);
            check($sformatf("starve%0d_b_ready", i), pre_b_ready, (i == 4) ? 1 : 0);
            check($sformatf("starve%0d_wb_rd", i),   bus.wb_rd,   (i == 4) ? 7 : 10 + i);
        end

        // Random traffic, register numbers concentrated to force collisions
        for (int n = 0; n < 400; n++) begin
            v.a_valid     = ($urandom_range(0, 3) != 0);
            v.a_rd        = 5'($urandom_range(0, 7));
            v.a_data      = $urandom;
            v.b_valid     = ($urandom_range(0, 2) != 0);
            v.b_rd        = 5'($urandom_range(0, 7));
            v.b_data      = $urandom;
            v.issue_valid = ($urandom_range(0, 2) == 0);
            v.issue_rd    = 5'($urandom_range(0, 7));
            v.rs          = 5'($urandom_range(0, 7));
            v.rt          = 5'($urandom_range(0, 31));
            cycle(v);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
